// File: rtl/niosii_system_pio_buttons_pkg.sv
// Shared register map, edge-mode encodings and sizing helper for the button PIO.
// Imported by the top level and by the per-bit debounce slice.
package niosii_system_pio_buttons_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

   // Debounce counter width; a one-bit counter is the floor.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a saturating stability counter.
// The debounced level changes only after DEBOUNCE_CYCLES consecutive differing samples.
module pio_debounce_bit
   import niosii_system_pio_buttons_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic        RESET_BIT       = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic stable
);

   localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_MAX  = '1;

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_BIT;
         sync <= RESET_BIT;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         stable <= RESET_BIT;
      end else if (sync == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= sync;
         cnt    <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/niosii_system_pio_buttons.sv
// Avalon-MM input PIO for push-buttons: debounced data, IRQ mask, W1C edge capture
// and a level interrupt.
module niosii_system_pio_buttons
   import niosii_system_pio_buttons_pkg::*;
#(
   parameter int unsigned       WIDTH           = 4,
   parameter int unsigned       DEBOUNCE_CYCLES = 50000,
   parameter int unsigned       EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0]  RESET_LEVEL     = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] clr;
   logic [31:0]      rd_mux;
   logic             wr;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_BIT       (RESET_LEVEL[i])
      ) u_db (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (in_port[i]),
         .stable  (stable[i])
      );
   end

   assign wr           = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev <= RESET_LEVEL;
      else          prev <= stable;
   end

   always_comb begin
      edge_det = '0;
      case (EDGE_TYPE)
         EDGE_RISE: edge_det = stable & ~prev;
         EDGE_FALL: edge_det = ~stable & prev;
         EDGE_ANY:  edge_det = stable ^ prev;
         default:   edge_det = '0;
      endcase
   end

   always_comb begin
      clr = '0;
      if (wr && address == ADDR_EDGECAP) clr = writedata[WIDTH-1:0];
   end

   // A new edge in the same cycle as a W1C write of that bit keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) edge_capture <= '0;
      else          edge_capture <= edge_det | (edge_capture & ~clr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          irq_mask <= '0;
      else if (wr && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
         ADDR_RSVD:    rd_mux            = '0;
         ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
         ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
         default:      rd_mux            = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_mux;
   end

   assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_niosii_system_pio_buttons.sv
// Directed bench for the button PIO: one falling-edge instance and one any-edge
// instance share every input; expected values are worked out by hand.
module tb_niosii_system_pio_buttons;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;
   logic [31:0] rd_any;
   logic        irq_any;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   niosii_system_pio_buttons #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .EDGE_TYPE       (1),
      .RESET_LEVEL     (4'hF)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   niosii_system_pio_buttons #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .EDGE_TYPE       (2),
      .RESET_LEVEL     (4'hF)
   ) dut_any (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (rd_any),
      .irq        (irq_any)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int unsigned n = 1);
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic read_both(input string tag, input logic [1:0] a,
                            input logic [31:0] exp, input logic [31:0] exp_any);
      address = a;
      tick();
      check_val({tag, "_f"}, readdata, exp);
      check_val({tag, "_a"}, rd_any, exp_any);
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 4'hF;
      tick(2);
      check_val("rst_rd", readdata, 32'h0);
      check_val("rst_irq", {31'd0, irq}, 32'h0);
      reset_n = 1'b1;

      // Register map straight out of reset
      read_both("t1_data", 2'd0, 32'hF, 32'hF);
      read_both("t1_rsvd", 2'd1, 32'h0, 32'h0);
      read_both("t1_mask", 2'd2, 32'h0, 32'h0);
      read_both("t1_cap",  2'd3, 32'h0, 32'h0);
      check_val("t1_irq", {31'd0, irq}, 32'h0);

      // Falling bit 0: stable moves on edge 6, readdata shows it on edge 7
      address = 2'd0;
      in_port = 4'hE;
      tick(6);
      check_val("t2_data_e6", readdata, 32'hF);
      tick();
      check_val("t2_data_e7", readdata, 32'hE);
      check_val("t2_irq_masked", {31'd0, irq}, 32'h0);
      read_both("t2_cap", 2'd3, 32'h1, 32'h1);
      check_val("t2_irq_masked2", {31'd0, irq}, 32'h0);

      // Mask, W1C of a clear bit, W1C of the set bit
      bus_write(2'd2, 32'h1);
      check_val("t3_irq_on", {31'd0, irq}, 32'h1);
      bus_write(2'd3, 32'h2);
      check_val("t3_irq_kept", {31'd0, irq}, 32'h1);
      read_both("t3_cap_kept", 2'd3, 32'h1, 32'h1);
      bus_write(2'd3, 32'h1);
      check_val("t3_irq_off", {31'd0, irq}, 32'h0);
      read_both("t3_cap_clr", 2'd3, 32'h0, 32'h0);
      read_both("t3_mask", 2'd2, 32'h1, 32'h1);

      // Three-cycle glitch on bit 1 must be rejected
      address = 2'd0;
      in_port = 4'hC;
      tick(3);
      in_port = 4'hE;
      tick(8);
      check_val("t4_data", readdata, 32'hE);
      read_both("t4_cap", 2'd3, 32'h0, 32'h0);

      // Rising bit 0: captured only by the any-edge instance
      address = 2'd0;
      in_port = 4'hF;
      tick(6);
      check_val("t5_data_e6", readdata, 32'hE);
      tick();
      check_val("t5_data_e7", readdata, 32'hF);
      read_both("t5_cap", 2'd3, 32'h0, 32'h1);
      check_val("t5_irq_f", {31'd0, irq}, 32'h0);
      check_val("t5_irq_a", {31'd0, irq_any}, 32'h1);

      // Bit 2 edge coincides with a W1C of bit 2 on edge 7
      address = 2'd0;
      in_port = 4'hB;
      tick(6);
      bus_write(2'd3, 32'h4);
      read_both("t6_set_wins", 2'd3, 32'h4, 32'h5);

      // Reset in the middle of a bit-3 debounce
      in_port = 4'hF;
      tick(8);
      address = 2'd0;
      in_port = 4'h7;
      tick(3);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("t6_rst_rd_f", readdata, 32'h0);
      check_val("t6_rst_rd_a", rd_any, 32'h0);
      check_val("t6_rst_irq_a", {31'd0, irq_any}, 32'h0);
      tick(2);
      reset_n = 1'b1;
      read_both("t6_mask_rst", 2'd2, 32'h0, 32'h0);
      read_both("t6_cap_rst",  2'd3, 32'h0, 32'h0);
      read_both("t6_data_rst", 2'd0, 32'hF, 32'hF);
      tick(4);
      check_val("t6_data_new", readdata, 32'h7);
      read_both("t6_cap_new", 2'd3, 32'h8, 32'h8);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
